// File: rtl/game_pkg.sv
// Shared types and constants for the volcano flight game controller.
// Optional pause support is selected with the GAME_SEQ_PAUSE_EN macro.
package game_pkg;

  localparam int unsigned POS_W      = 10;
  localparam int unsigned SUM_W      = POS_W + 1;
  localparam int unsigned SCREEN_TOP = 40;
  localparam int unsigned SCREEN_BOT = 400;

`ifdef GAME_SEQ_PAUSE_EN
  localparam int unsigned STATE_W = 3;
`else
  localparam int unsigned STATE_W = 2;
`endif

  typedef logic [SUM_W-1:0] sum_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PLAY  = 3'd1,
    ST_HIT   = 3'd2,
    ST_OVER  = 3'd3,
    ST_PAUSE = 3'd4
  } state_e;

  // 1-D interval overlap: [a_lo, a_lo+a_len) meets [b_lo, b_lo+b_len).
  // Operands are one bit wider than a position, so the sums cannot wrap.
  function automatic logic span_hit(input sum_t a_lo, input sum_t a_len,
                                    input sum_t b_lo, input sum_t b_len);
    return (a_lo < b_lo + b_len) && (a_lo + a_len > b_lo);
  endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// Bundle of game_sequencer inputs/outputs. The pause line exists only when
// GAME_SEQ_PAUSE_EN is defined.
interface game_sequencer_if;
  import game_pkg::*;

  logic               start;
`ifdef GAME_SEQ_PAUSE_EN
  logic               pause;
`endif
  logic [POS_W-1:0]   plane_y;
  logic [POS_W-1:0]   lava_x;
  logic [POS_W-1:0]   lava_y;
  logic [POS_W-1:0]   mtn1_x;
  logic [POS_W-1:0]   mtn1_y;
  logic [POS_W-1:0]   mtn2_x;
  logic [POS_W-1:0]   mtn2_y;
  logic               pass_inc;
  logic               move_tick;
  logic               game_over;
  logic [STATE_W-1:0] state;
  logic [1:0]         lives;
  logic [7:0]         score;

  // Driver side (board / bench).
  modport master (
    output start,
`ifdef GAME_SEQ_PAUSE_EN
    output pause,
`endif
    output plane_y, lava_x, lava_y, mtn1_x, mtn1_y, mtn2_x, mtn2_y, pass_inc,
    input  move_tick, game_over, state, lives, score
  );

  // Sequencer side.
  modport slave (
    input  start,
`ifdef GAME_SEQ_PAUSE_EN
    input  pause,
`endif
    input  plane_y, lava_x, lava_y, mtn1_x, mtn1_y, mtn2_x, mtn2_y, pass_inc,
    output move_tick, game_over, state, lives, score
  );

endinterface

// File: rtl/game_sequencer_tick_divider.sv
// Free-running divider: tick is high for one cycle out of every TICK_DIV.
module tick_divider #(
  parameter int unsigned TICK_DIV = 833333
) (
  input  logic clk,
  input  logic resetn,
  output logic tick
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0] cnt_q;

  assign tick = (cnt_q == CNT_W'(TICK_DIV - 1));

  // Count 0..TICK_DIV-1 and wrap on the tick cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// Top-level game controller: movement tick, plane/obstacle collision check,
// game FSM (idle/play/hit/over), lives and score. Defining GAME_SEQ_PAUSE_EN
// adds a pause input and a PAUSE state (encoding 4, 3-bit state output).
module game_sequencer
  import game_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 833333,
  parameter int unsigned LIVES     = 3,
  parameter int unsigned HIT_TICKS = 30,
  parameter int unsigned PLANE_X   = 40,
  parameter int unsigned PLANE_W   = 32,
  parameter int unsigned PLANE_H   = 16,
  parameter int unsigned OBJ_W     = 16
) (
  input  logic           clk,
  input  logic           resetn,
  game_sequencer_if.slave gs
);

  localparam int unsigned HIT_W = $clog2(HIT_TICKS + 1);

  state_e           state_q;
  logic             game_over_q;
  logic [1:0]       lives_q;
  logic [7:0]       score_q;
  logic [HIT_W-1:0] hit_cnt_q;
  logic             start_q;
  logic             start_rise;
  logic             move_tick;
  logic             x_lava, x_mtn1, x_mtn2;
  logic             lava_hit, mtn1_hit, mtn2_hit, collide;

  tick_divider #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .resetn(resetn),
    .tick  (move_tick)
  );

  assign start_rise = gs.start & ~start_q;

`ifdef GAME_SEQ_PAUSE_EN
  logic pause_q;
  logic pause_rise;
  assign pause_rise = gs.pause & ~pause_q;
`endif

  // Bounding-box overlap; mountains extend from their peak to the screen bottom.
  always_comb begin
    x_lava   = span_hit(sum_t'(gs.lava_x), sum_t'(OBJ_W), sum_t'(PLANE_X), sum_t'(PLANE_W));
    x_mtn1   = span_hit(sum_t'(gs.mtn1_x), sum_t'(OBJ_W), sum_t'(PLANE_X), sum_t'(PLANE_W));
    x_mtn2   = span_hit(sum_t'(gs.mtn2_x), sum_t'(OBJ_W), sum_t'(PLANE_X), sum_t'(PLANE_W));
    lava_hit = x_lava &&
               span_hit(sum_t'(gs.lava_y), sum_t'(OBJ_W), sum_t'(gs.plane_y), sum_t'(PLANE_H));
    mtn1_hit = x_mtn1 && (sum_t'(gs.plane_y) + sum_t'(PLANE_H) > sum_t'(gs.mtn1_y));
    mtn2_hit = x_mtn2 && (sum_t'(gs.plane_y) + sum_t'(PLANE_H) > sum_t'(gs.mtn2_y));
    collide  = lava_hit | mtn1_hit | mtn2_hit;
  end

  // Game FSM with registered game_over, lives, score and hit-freeze counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      game_over_q <= 1'b1;
      lives_q     <= 2'(LIVES);
      score_q     <= '0;
      hit_cnt_q   <= '0;
      start_q     <= 1'b0;
`ifdef GAME_SEQ_PAUSE_EN
      pause_q     <= 1'b0;
`endif
    end else begin
      start_q <= gs.start;
`ifdef GAME_SEQ_PAUSE_EN
      pause_q <= gs.pause;
`endif
      unique case (state_q)
        ST_IDLE: begin
          if (start_rise) begin
            state_q     <= ST_PLAY;
            game_over_q <= 1'b0;
            lives_q     <= 2'(LIVES);
            score_q     <= '0;
          end
        end
        ST_PLAY: begin
          // A pass in the collision cycle still scores.
          if (gs.pass_inc && (score_q != 8'hFF)) begin
            score_q <= score_q + 8'd1;
          end
`ifdef GAME_SEQ_PAUSE_EN
          if (pause_rise) begin
            state_q     <= ST_PAUSE;
            game_over_q <= 1'b1;
          end else
`endif
          if (move_tick && collide) begin
            state_q     <= ST_HIT;
            game_over_q <= 1'b1;
            lives_q     <= lives_q - 2'd1;
            hit_cnt_q   <= '0;
          end
        end
        ST_HIT: begin
          if (move_tick) begin
            if (hit_cnt_q == HIT_W'(HIT_TICKS - 1)) begin
              if (lives_q == 2'd0) begin
                state_q <= ST_OVER;
              end else begin
                state_q     <= ST_PLAY;
                game_over_q <= 1'b0;
              end
            end else begin
              hit_cnt_q <= hit_cnt_q + 1'b1;
            end
          end
        end
        ST_OVER: begin
          // Back to idle only; a fresh start edge is needed to play again.
          if (start_rise) begin
            state_q <= ST_IDLE;
          end
        end
`ifdef GAME_SEQ_PAUSE_EN
        ST_PAUSE: begin
          if (pause_rise) begin
            state_q     <= ST_PLAY;
            game_over_q <= 1'b0;
          end
        end
`endif
        default: begin
          state_q     <= ST_IDLE;
          game_over_q <= 1'b1;
        end
      endcase
    end
  end

  assign gs.move_tick = move_tick;
  assign gs.game_over = game_over_q;
  assign gs.state     = state_q[STATE_W-1:0];
  assign gs.lives     = lives_q;
  assign gs.score     = score_q;

endmodule
